seconds_ticker: RTL and testbench
=================================

// Module: seconds_ticker
// PURPOSE
//  Generates the seconds ones digit of the survival timer from CLOCK_50. Counts
//  whole seconds 0..9 while the game runs and freezes on collision.
//  Drives binary_time of the downstream digit counter/7-seg stage.
//  Adds a one-cycle wrap pulse so the tens/hundreds stage advances exactly once.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  CLOCK_50 cycles per second; set to 4 in sim.
//  DIGIT_MAX      9           last ones value before wrap to 0.
// PORTS
//  CLOCK_50     in   1  system clock, 50 MHz
//  reset        in   1  asynchronous, active-high; clears all state
//  key_press    in   1  level; rising edge starts or restarts a run
//  collided     in   1  level; high = pipe/box collision, stop counting
//  binary_time  out  4  seconds ones digit, 0..DIGIT_MAX
//  sec_tick     out  1  1-cycle pulse on every counted second
//  digit_carry  out  1  1-cycle pulse when binary_time wraps DIGIT_MAX->0
//  running      out  1  high while in RUNNING
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, prescaler=0, binary_time=0,
//    sec_tick=0, digit_carry=0, running=0, key edge register=0.
//  - key_press is double-flopped. kp_rise = synced & ~synced_d.
//    Edge lands 2-3 cycles after the pin.
//  - Prescaler width = $clog2(TICKS_PER_SEC); counts 0..TICKS_PER_SEC-1 only in RUNNING.
//  - FSM:
//    IDLE:    outputs held at 0; kp_rise -> RUNNING, prescaler=0.
//    RUNNING: running=1. Each cycle prescaler++.
//             At prescaler==TICKS_PER_SEC-1: prescaler<=0, sec_tick<=1 next cycle.
//             binary_time<=binary_time+1. If binary_time==DIGIT_MAX:
//             binary_time<=0 and digit_carry<=1 in the same cycle as sec_tick.
//             collided==1 -> STOPPED.
//    STOPPED: binary_time and prescaler frozen, sec_tick=digit_carry=0.
//             kp_rise -> clear prescaler/binary_time, go RUNNING.
//             kp_rise ignored while collided still high.
//  - Priority in RUNNING: collided beats terminal count. No increment and no pulses
//    in the collision cycle.
//  - kp_rise while RUNNING is ignored; no restart mid-run.
//  - binary_time never exceeds DIGIT_MAX; values DIGIT_MAX+1..15 are unreachable.
//  - Pulses are registered and exactly one cycle wide.
//  - First tick comes TICKS_PER_SEC cycles after entering RUNNING.
// TESTING  (TICKS_PER_SEC=4)
//  1. Reset, then key_press 0->1 -> running=1 after <=3 cycles.
//     sec_tick every 4 cycles; binary_time 1,2,3.
//  2. Run 10 ticks -> binary_time 9 then 0. digit_carry=1 only on the 9->0 cycle,
//     coincident with sec_tick.
//  3. collided=1 on the terminal-count cycle -> no tick, no increment.
//     STOPPED with binary_time held; it stays held over 20 cycles.
//  4. In STOPPED: key_press rises while collided=1 -> no change.
//     collided=0, then key_press rises -> binary_time=0, RUNNING.
//     First tick 4 cycles later.
//  5. Assert reset mid-count (binary_time=6, prescaler=2) -> all outputs 0
//     asynchronously, before the next clock edge; state IDLE.
//  6. key_press held high for 50 cycles in IDLE -> exactly one start.
//     A second rise while RUNNING -> no effect.

Source files
------------

// File: rtl/seconds_ticker_if.sv
// rtl/seconds_ticker_if.sv - Player controls and timer outputs of the seconds ticker
interface seconds_ticker_if;
  logic       key_press;
  logic       collided;
  logic [3:0] binary_time;
  logic       sec_tick;
  logic       digit_carry;
  logic       running;

  modport slave (
    input  key_press,
    input  collided,
    output binary_time,
    output sec_tick,
    output digit_carry,
    output running
  );

  modport master (
    output key_press,
    output collided,
    input  binary_time,
    input  sec_tick,
    input  digit_carry,
    input  running
  );
endinterface

// File: rtl/seconds_ticker.sv
// rtl/seconds_ticker.sv - Seconds ones digit of the survival timer with wrap pulse
module seconds_ticker #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DIGIT_MAX     = 9
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  seconds_ticker_if.slave  bus
);
  localparam int             PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]     DIG_LAST = 4'(DIGIT_MAX);

  typedef enum logic [1:0] {IDLE, RUNNING, STOPPED} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_kp_s1, r_kp_s2, r_kp_d;
  logic          w_kp_rise;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [3:0]    r_bin, w_bin_nxt;
  logic          r_tick, w_tick_nxt;
  logic          r_carry, w_carry_nxt;

  // key_press is asynchronous to CLOCK_50; two flops before edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_kp_s1 <= 1'b0;
      r_kp_s2 <= 1'b0;
      r_kp_d  <= 1'b0;
    end else begin
      r_kp_s1 <= bus.key_press;
      r_kp_s2 <= r_kp_s1;
      r_kp_d  <= r_kp_s2;
    end
  end

  assign w_kp_rise = r_kp_s2 & ~r_kp_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_bin   <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_bin   <= w_bin_nxt;
      r_tick  <= w_tick_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_bin_nxt   = r_bin;
    w_tick_nxt  = 1'b0;
    w_carry_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_pre_nxt = '0;
        w_bin_nxt = '0;
        if (w_kp_rise) w_state_nxt = RUNNING;
      end
      RUNNING: begin
        // A collision on the terminal-count cycle swallows that second
        if (bus.collided) begin
          w_state_nxt = STOPPED;
        end else if (r_pre == PRE_LAST) begin
          w_pre_nxt  = '0;
          w_tick_nxt = 1'b1;
          if (r_bin == DIG_LAST) begin
            w_bin_nxt   = '0;
            w_carry_nxt = 1'b1;
          end else begin
            w_bin_nxt = r_bin + 4'd1;
          end
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end
      STOPPED: begin
        if (w_kp_rise && !bus.collided) begin
          w_state_nxt = RUNNING;
          w_pre_nxt   = '0;
          w_bin_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pre_nxt   = '0;
        w_bin_nxt   = '0;
      end
    endcase
  end

  assign bus.binary_time = r_bin;
  assign bus.sec_tick    = r_tick;
  assign bus.digit_carry = r_carry;
  assign bus.running     = (r_state == RUNNING);
endmodule

// File: tb/tb_seconds_ticker.sv
// tb/tb_seconds_ticker.sv - Randomized and directed bench against a seconds/cycle count model
module tb_seconds_ticker;
  localparam int T  = 4;
  localparam int DM = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seconds_ticker_if bus ();

  seconds_ticker #(.TICKS_PER_SEC(T), .DIGIT_MAX(DM)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state 0=idle 1=running 2=stopped; time kept as elapsed run cycles and whole seconds
  int m_state = 0;
  int m_cycles = 0;
  int m_secs = 0;
  bit m_tick = 0, m_carry = 0;
  bit p1 = 0, p2 = 0, p3 = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rise;
    if (rst) begin
      m_state = 0; m_cycles = 0; m_secs = 0; m_tick = 0; m_carry = 0;
      p1 = 0; p2 = 0; p3 = 0;
      return;
    end
    rise = p2 & ~p3;
    p3 = p2; p2 = p1; p1 = bus.key_press;
    m_tick = 0; m_carry = 0;
    case (m_state)
      0: if (rise) begin m_state = 1; m_cycles = 0; m_secs = 0; end
      1: begin
        if (bus.collided) m_state = 2;
        else begin
          m_cycles++;
          if (m_cycles % T == 0) begin
            m_tick = 1;
            m_secs++;
            m_carry = (m_secs % (DM + 1)) == 0;
          end
        end
      end
      default: if (rise && !bus.collided) begin m_state = 1; m_cycles = 0; m_secs = 0; end
    endcase
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_val("binary_time", int'(bus.binary_time), m_secs % (DM + 1));
      check_val("sec_tick", int'(bus.sec_tick), int'(m_tick));
      check_val("digit_carry", int'(bus.digit_carry), int'(m_carry));
      check_val("running", int'(bus.running), int'(m_state == 1));
    end
  endtask

  int held;
  int starts;
  bit found;

  initial begin
    bus.key_press = 1'b0;
    bus.collided  = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);

    // Start and count through several wraps
    bus.key_press = 1'b1;
    step(20);
    step(30);

    // Collide on a terminal-count cycle
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_state == 1 && (m_cycles % T) == T - 1) found = 1;
      else step(1);
    end
    check_val("reach_terminal", int'(found), 1);
    held = m_secs % (DM + 1);
    bus.collided = 1'b1;
    step(1);
    check_val("collide_no_tick", int'(bus.sec_tick), 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_val("held_time", int'(bus.binary_time), held);
    end

    // Rise while still collided is ignored, then a clean restart
    bus.key_press = 1'b0;
    step(4);
    bus.key_press = 1'b1;
    step(6);
    check_val("stopped_kp_collided", int'(bus.running), 0);
    bus.collided = 1'b0;
    bus.key_press = 1'b0;
    step(4);
    bus.key_press = 1'b1;
    step(12);

    // Asynchronous reset at binary_time=6, prescaler=2
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_state == 1 && (m_secs % (DM + 1)) == 6 && (m_cycles % T) == 2) found = 1;
      else step(1);
    end
    check_val("reach_6_2", int'(found), 1);
    check_val("pre_reset_time", int'(bus.binary_time), 6);
    #2 rst = 1'b1;
    #1;
    check_val("async_time", int'(bus.binary_time), 0);
    check_val("async_tick", int'(bus.sec_tick), 0);
    check_val("async_carry", int'(bus.digit_carry), 0);
    check_val("async_running", int'(bus.running), 0);
    bus.key_press = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // Held key gives one start; a second rise mid-run does nothing
    bus.key_press = 1'b1;
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      held = int'(bus.running);
      step(1);
      if (held == 0 && bus.running) starts++;
    end
    check_val("single_start", starts, 1);
    bus.key_press = 1'b0;
    step(5);
    bus.key_press = 1'b1;
    step(15);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.key_press = ~bus.key_press;
      if ($urandom_range(0, 15) == 0) bus.collided = ~bus.collided;
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
